note_tone_gen: RTL
==================

Name: note_tone_gen

Overview:
Downstream stage of the music sequencer. It takes the sequencer's note strobe and 4-bit note code and produces the square-wave PWM and amplifier shutdown (sd) signals for the on-board audio jack. Each triggered note plays for a fixed duration, then a short silent articulation gap, then the block goes idle. The sequencer gates pwm/sd with its own state, so this block owns only tone generation and note timing.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; used for half-period computation
DUR_CYCLES, CLK_HZ/4, tone duration in clk cycles (250 ms)
GAP_CYCLES, CLK_HZ/100, silent gap after the tone, sd held high (10 ms)

Ports:
clk  in  1  system clock, single clock domain
rstn  in  1  asynchronous, active-low reset
note_en  in  1  note strobe; only its rising edge triggers
note  in  4  note code, sampled on the same edge as the note_en rising edge
pwm  out  1  square-wave audio output
sd  out  1  amplifier enable, 1 = on
busy  out  1  high in PLAY or GAP
cur_note  out  4  latched note code; 0 when idle

Behaviour:
- Reset (rstn=0, async): state=IDLE; pwm=0, sd=0, busy=0, cur_note=0; all counters 0; edge register 0.
- Edge detect: note_en_d is registered every cycle. trig = note_en & ~note_en_d. A level held for N cycles produces one trigger.
- Note table: codes 1..15 map to C4 D4 E4 F4 G4 A4 B4 C5 D5 E5 F5 G5 A5 B5 C6 = 262 294 330 349 392 440 494 523 587 659 698 784 880 988 1047 Hz. half = CLK_HZ/(2*f), integer division, computed at elaboration, 32 bits. Code 0 = rest.
- States: IDLE, PLAY, GAP (2-bit).
- On trig with note!=0, from any state, at that clock edge:
  - state=PLAY, cur_note=note, half loaded.
  - phase_cnt=0, dur_cnt=0, pwm=1, sd=1.
  - Outputs are visible in the cycle after the edge where note_en is first sampled high (1-cycle latency).
- On trig with note==0, from any state: state=IDLE, pwm=0, sd=0, cur_note=0.
- PLAY, each cycle:
  - phase_cnt increments; when phase_cnt==half-1 it wraps to 0 and pwm toggles. Period is exactly 2*half cycles.
  - dur_cnt increments; when dur_cnt==DUR_CYCLES-1: state=GAP, pwm=0, dur_cnt=0.
- GAP: pwm=0, sd=1. When dur_cnt==GAP_CYCLES-1: state=IDLE, sd=0, cur_note=0.
- IDLE: pwm=0, sd=0.
- busy = (state!=IDLE), combinational from the state register.
- Priority: trig beats duration/gap expiry in the same cycle (the new note starts; no GAP).
- A retrigger mid-PLAY with the same or a different code restarts phase and duration.
- A trig in GAP starts a new note immediately.
- Counters never wrap beyond their terminal compare. Parameters satisfy DUR_CYCLES>=1, GAP_CYCLES>=1 (elaboration assertion).

Decomposition:
- Package note_pkg holds:
  - the state enum (IDLE/PLAY/GAP);
  - the 16-entry note frequency table (Hz, code 0 = 0);
  - function half_period(code, clk_hz), returning 0 for code 0.
- One sub-module, tone_osc: half-period register, phase counter and pwm toggle, with load/clear inputs.
- note_tone_gen keeps edge detection, the FSM, the duration counter, sd, busy and cur_note.

Test Plan (CLK_HZ=1_000_000, DUR_CYCLES=10000, GAP_CYCLES=500):
1. Hold rstn=0 5 cycles, then release -> pwm=0, sd=0, busy=0, cur_note=0; these values also hold during reset with note_en toggling.
2. Set note=6 and raise note_en for 1 cycle -> next cycle pwm=1, sd=1, cur_note=6. Then:
   - pwm toggles every 1136 cycles for 10000 cycles;
   - pwm=0, sd=1 for 500 cycles;
   - sd=0, busy=0, cur_note=0.
3. Hold note_en high 3 cycles with note=6 -> exactly one trigger; duration ends 10000 cycles after the first edge.
4. At cycle 3000 of the A4 note, pulse note_en with note=13 -> cur_note=13, pwm=1 and phase restarts (toggles every 568 cycles), and PLAY lasts 10000 cycles from the retrigger.
5. During PLAY, pulse note_en with note=0 -> next cycle pwm=0, sd=0, busy=0, with no GAP. Separately, trigger on exactly the cycle PLAY expires -> new note starts and GAP is skipped.
6. Assert rstn=0 asynchronously mid-PLAY (between clock edges) -> pwm, sd, busy and cur_note go to 0 without a clock edge. After release, remains IDLE until the next note_en rising edge.

Source files
------------

// File: rtl/note_pkg.sv
//------------------------------------------------------------------------------
// note_pkg : shared types, note frequency table and half-period helper
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package note_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Code 0 is a rest; codes 1..15 run C4 up to C6.
    localparam int unsigned NOTE_HZ [16] = '{
        0,   262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988, 1047
    };

    function automatic logic [31:0] half_period(input logic [3:0] code,
                                                input int unsigned clk_hz);
        if (code == 4'd0) begin
            return 32'd0;
        end
        return clk_hz / (2 * NOTE_HZ[code]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_tone_gen_osc.sv
//------------------------------------------------------------------------------
// tone_osc : square-wave oscillator with loadable half period
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tone_osc (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] half_in,
    output logic        pwm
);

    logic [31:0] r_half;
    logic [31:0] r_phase;
    logic        r_pwm;
    logic        w_wrap;

    // A half period of 0 or 1 degenerates to toggling every cycle.
    assign w_wrap = ((r_phase + 32'd1) >= r_half);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_half  <= 32'd0;
            r_phase <= 32'd0;
            r_pwm   <= 1'b0;
        end else if (load) begin
            r_half  <= half_in;
            r_phase <= 32'd0;
            r_pwm   <= 1'b1;
        end else if (clear) begin
            r_phase <= 32'd0;
            r_pwm   <= 1'b0;
        end else if (run) begin
            if (w_wrap) begin
                r_phase <= 32'd0;
                r_pwm   <= ~r_pwm;
            end else begin
                r_phase <= r_phase + 32'd1;
            end
        end
    end

    assign pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/note_tone_gen.sv
//------------------------------------------------------------------------------
// note_tone_gen : note strobe to timed square-wave tone plus amplifier enable
// Rev 1.0       : initial release
//------------------------------------------------------------------------------
`default_nettype none

module note_tone_gen
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned DUR_CYCLES = CLK_HZ / 4,
    parameter int unsigned GAP_CYCLES = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       note_en,
    input  logic [3:0] note,
    output logic       pwm,
    output logic       sd,
    output logic       busy,
    output logic [3:0] cur_note
);

    localparam logic [31:0] c_dur_last = 32'(DUR_CYCLES - 1);
    localparam logic [31:0] c_gap_last = 32'(GAP_CYCLES - 1);

    generate
        if (DUR_CYCLES == 0 || GAP_CYCLES == 0) begin : g_param_check
            $error("note_tone_gen: DUR_CYCLES and GAP_CYCLES must be at least 1");
        end
    endgenerate

    logic [31:0] w_half_tab [16];

    generate
        for (genvar i = 0; i < 16; i++) begin : g_half_tab
            assign w_half_tab[i] = half_period(4'(i), CLK_HZ);
        end
    endgenerate

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_dur,      w_dur_nxt;
    logic [3:0]  r_cur_note, w_cur_note_nxt;
    logic        r_sd,       w_sd_nxt;
    logic        r_note_en_d;
    logic        w_trig;
    logic        w_load;
    logic        w_clear;
    logic        w_run;

    assign w_trig = note_en & ~r_note_en_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_dur       <= 32'd0;
            r_cur_note  <= 4'd0;
            r_sd        <= 1'b0;
            r_note_en_d <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dur       <= w_dur_nxt;
            r_cur_note  <= w_cur_note_nxt;
            r_sd        <= w_sd_nxt;
            r_note_en_d <= note_en;
        end
    end

    // A trigger outranks any expiry in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_dur_nxt      = r_dur;
        w_cur_note_nxt = r_cur_note;
        w_sd_nxt       = r_sd;
        w_load         = 1'b0;
        w_clear        = 1'b0;
        if (w_trig) begin
            w_dur_nxt = 32'd0;
            if (note != 4'd0) begin
                w_state_nxt    = ST_PLAY;
                w_cur_note_nxt = note;
                w_sd_nxt       = 1'b1;
                w_load         = 1'b1;
            end else begin
                w_state_nxt    = ST_IDLE;
                w_cur_note_nxt = 4'd0;
                w_sd_nxt       = 1'b0;
                w_clear        = 1'b1;
            end
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (r_dur == c_dur_last) begin
                        w_state_nxt = ST_GAP;
                        w_dur_nxt   = 32'd0;
                        w_clear     = 1'b1;
                    end else begin
                        w_dur_nxt = r_dur + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (r_dur == c_gap_last) begin
                        w_state_nxt    = ST_IDLE;
                        w_dur_nxt      = 32'd0;
                        w_sd_nxt       = 1'b0;
                        w_cur_note_nxt = 4'd0;
                    end else begin
                        w_dur_nxt = r_dur + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dur_nxt   = 32'd0;
                    w_sd_nxt    = 1'b0;
                end
            endcase
        end
    end

    assign w_run = (r_state == ST_PLAY);

    tone_osc u_osc (
        .clk     (clk),
        .rstn    (rstn),
        .load    (w_load),
        .clear   (w_clear),
        .run     (w_run),
        .half_in (w_half_tab[note]),
        .pwm     (pwm)
    );

    assign sd       = r_sd;
    assign busy     = (r_state != ST_IDLE);
    assign cur_note = r_cur_note;

endmodule

`default_nettype wire
